// File: rtl/verificador_compuertas_pkg.sv
// Shared definitions for the gate-lab checker: FSM encoding and the bit
// positions of the per-vector mismatch mask.
package verificador_compuertas_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APLICAR  = 3'd1,
    ESPERAR  = 3'd2,
    COMPARAR = 3'd3,
    FIN      = 3'd4
  } estado_t;

  localparam int MASK_XOR_FN  = 0;
  localparam int MASK_AND_FN  = 1;
  localparam int MASK_XOR_EST = 2;
  localparam int MASK_AND_EST = 3;

endpackage

// File: rtl/verificador_compuertas_if.sv
// Bus between the checker and the gate bench it drives.
// Handshake: start is a one-cycle request honoured only in IDLE or FIN
// (ignored while busy); busy is high from the cycle after an accepted start
// until the sweep finishes; done then rises and holds, together with pass,
// err_count, fail_vec and fail_mask, until the next accepted start or reset.
// estado is a debug view of the FSM state.
interface verificador_compuertas_if #(
  parameter int N_BITS = 2,
  parameter int ERR_W  = 8
);
  import verificador_compuertas_pkg::*;

  logic              start;
  logic              rta_xor_fn;
  logic              rta_and_fn;
  logic              rta_xor_est;
  logic              rta_and_est;
  logic [N_BITS-1:0] estimulo;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [N_BITS-1:0] fail_vec;
  logic [3:0]        fail_mask;
  estado_t           estado;

  modport master (
    output start, rta_xor_fn, rta_and_fn, rta_xor_est, rta_and_est,
    input  estimulo, busy, done, pass, err_count, fail_vec, fail_mask, estado
  );

  modport slave (
    input  start, rta_xor_fn, rta_and_fn, rta_xor_est, rta_and_est,
    output estimulo, busy, done, pass, err_count, fail_vec, fail_mask, estado
  );

endinterface

// File: rtl/verificador_compuertas_modelo.sv
// Golden model of the gates under test: XOR and AND across the whole vector.
module modelo_compuertas #(
  parameter int N_BITS = 2
) (
  input  logic [N_BITS-1:0] estimulo,
  output logic              esp_xor,
  output logic              esp_and
);

  // Pure reduction operators; no state.
  always_comb begin
    esp_xor = ^estimulo;
    esp_and = &estimulo;
  end

endmodule

// File: rtl/verificador_compuertas.sv
// Sweeps every input vector through the gates under test, waits for the
// responses to settle, compares them against the golden model and keeps a
// saturating error count plus the first failing vector and mask.
module verificador_compuertas
  import verificador_compuertas_pkg::*;
#(
  parameter int N_BITS        = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input logic                     clk,
  input logic                     reset_L,
  verificador_compuertas_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  estado_t           estado;
  logic [N_BITS-1:0] idx;
  logic [CW-1:0]     cnt;
  logic              first_fail;
  logic [N_BITS-1:0] estimulo;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [N_BITS-1:0] fail_vec;
  logic [3:0]        fail_mask;
  logic              esp_xor;
  logic              esp_and;
  logic [3:0]        mask;

  modelo_compuertas #(.N_BITS(N_BITS)) u_modelo (
    .estimulo (estimulo),
    .esp_xor  (esp_xor),
    .esp_and  (esp_and)
  );

  // Per-gate mismatch of the current responses against the golden model.
  always_comb begin
    mask               = '0;
    mask[MASK_XOR_FN]  = bus.rta_xor_fn  ^ esp_xor;
    mask[MASK_AND_FN]  = bus.rta_and_fn  ^ esp_and;
    mask[MASK_XOR_EST] = bus.rta_xor_est ^ esp_xor;
    mask[MASK_AND_EST] = bus.rta_and_est ^ esp_and;
  end

  // Sweep sequencer; all results are registered here.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      estado     <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      first_fail <= 1'b0;
      estimulo   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_mask  <= '0;
    end else begin
      case (estado)
        IDLE, FIN: begin
          if (bus.start) begin
            idx        <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_mask  <= '0;
            first_fail <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            estado     <= APLICAR;
          end else if (estado == FIN) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0);
          end
        end
        APLICAR: begin
          estimulo <= idx;
          cnt      <= CW'(SETTLE_CYCLES);
          estado   <= ESPERAR;
        end
        ESPERAR: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) estado <= COMPARAR;
        end
        COMPARAR: begin
          if (mask != 4'b0000) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_fail) begin
              fail_vec   <= estimulo;
              fail_mask  <= mask;
              first_fail <= 1'b1;
            end
          end
          if (idx == '1) begin
            estado <= FIN;
          end else begin
            idx    <= idx + 1'b1;
            estado <= APLICAR;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign bus.estimulo  = estimulo;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.fail_vec  = fail_vec;
  assign bus.fail_mask = fail_mask;
  assign bus.estado    = estado;

endmodule

// File: tb/tb_verificador_compuertas.sv
// Bench for verificador_compuertas: a default instance (2-bit, 8-bit counter)
// and a 3-bit instance with a 2-bit counter, each fed by a model of the gates
// under test with selectable faults.
module tb_verificador_compuertas;
  import verificador_compuertas_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  verificador_compuertas_if #(.N_BITS(2), .ERR_W(8)) if_a ();
  verificador_compuertas_if #(.N_BITS(3), .ERR_W(2)) if_b ();

  verificador_compuertas #(.N_BITS(2), .SETTLE_CYCLES(2), .ERR_W(8)) dut_a (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (if_a)
  );

  verificador_compuertas #(.N_BITS(3), .SETTLE_CYCLES(2), .ERR_W(2)) dut_b (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (if_b)
  );

  // Gates under test: 0 = correct, 1 = xor_est stuck at 0, 2 = all inverted.
  int fault_a = 0;
  int fault_b = 0;

  assign if_a.rta_xor_fn  = (fault_a == 2) ? ~(^if_a.estimulo) : (^if_a.estimulo);
  assign if_a.rta_and_fn  = (fault_a == 2) ? ~(&if_a.estimulo) : (&if_a.estimulo);
  assign if_a.rta_xor_est = (fault_a == 1) ? 1'b0 :
                            (fault_a == 2) ? ~(^if_a.estimulo) : (^if_a.estimulo);
  assign if_a.rta_and_est = (fault_a == 2) ? ~(&if_a.estimulo) : (&if_a.estimulo);

  assign if_b.rta_xor_fn  = (fault_b == 2) ? ~(^if_b.estimulo) : (^if_b.estimulo);
  assign if_b.rta_and_fn  = (fault_b == 2) ? ~(&if_b.estimulo) : (&if_b.estimulo);
  assign if_b.rta_xor_est = (fault_b == 1) ? 1'b0 :
                            (fault_b == 2) ? ~(^if_b.estimulo) : (^if_b.estimulo);
  assign if_b.rta_and_est = (fault_b == 2) ? ~(&if_b.estimulo) : (&if_b.estimulo);

  // ---------------- scoreboard ----------------
  // Entry: {8'pass, 8'err_count, 8'fail_vec, 8'fail_mask}
  logic [31:0] exp_q[$];
  int n_asserts = 0;
  int n_fails   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected sweep results, computed bit by bit from the vector value.
  task automatic modelo(input int n, input int errw, input int mode,
                        output logic [31:0] r);
    int err, vec, msk, maxe, xe, ae, xf, af, xs, as_, m;
    bit ff;
    err = 0; vec = 0; msk = 0; ff = 0;
    maxe = (1 << errw) - 1;
    for (int v = 0; v < (1 << n); v++) begin
      xe = 0;
      for (int b = 0; b < n; b++) xe = xe ^ ((v >> b) & 1);
      ae = (v == (1 << n) - 1) ? 1 : 0;
      xf = xe; af = ae; xs = xe; as_ = ae;
      if (mode == 1) xs = 0;
      if (mode == 2) begin xf = 1 - xe; af = 1 - ae; xs = 1 - xe; as_ = 1 - ae; end
      m = ((as_ ^ ae) << 3) | ((xs ^ xe) << 2) | ((af ^ ae) << 1) | (xf ^ xe);
      if (m != 0) begin
        if (err < maxe) err++;
        if (!ff) begin vec = v; msk = m; ff = 1; end
      end
    end
    r = {8'((err == 0) ? 1 : 0), 8'(err), 8'(vec), 8'(msk)};
  endtask

  // ---------------- driver ----------------
  int s_est, s_busy, s_done, s_pass, s_err, s_vec, s_mask, s_state;

  task automatic sample(input int sel);
    if (sel == 0) begin
      s_est = int'(if_a.estimulo); s_busy = int'(if_a.busy); s_done = int'(if_a.done);
      s_pass = int'(if_a.pass); s_err = int'(if_a.err_count); s_vec = int'(if_a.fail_vec);
      s_mask = int'(if_a.fail_mask); s_state = int'(if_a.estado);
    end else begin
      s_est = int'(if_b.estimulo); s_busy = int'(if_b.busy); s_done = int'(if_b.done);
      s_pass = int'(if_b.pass); s_err = int'(if_b.err_count); s_vec = int'(if_b.fail_vec);
      s_mask = int'(if_b.fail_mask); s_state = int'(if_b.estado);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) if_a.start = v; else if_b.start = v;
  endtask

  task automatic check_idle(input string tag, input int sel);
    sample(sel);
    check({tag, "_state"}, s_state, int'(IDLE));
    check({tag, "_estimulo"}, s_est, 0);
    check({tag, "_busy"}, s_busy, 0);
    check({tag, "_done"}, s_done, 0);
    check({tag, "_pass"}, s_pass, 0);
    check({tag, "_err"}, s_err, 0);
    check({tag, "_fvec"}, s_vec, 0);
    check({tag, "_fmask"}, s_mask, 0);
  endtask

  // Full sweep: push the expected result, pulse start, then follow the run
  // cycle by cycle. glitch_cyc >= 0 re-pulses start to be sampled at that edge.
  task automatic run(input string tag, input int sel, input int n, input int errw,
                     input int mode, input int glitch_cyc, input int exp_cyc);
    logic [31:0] r;
    int cyc;
    bit seen;
    if (sel == 0) fault_a = mode; else fault_b = mode;
    modelo(n, errw, mode, r);
    exp_q.push_back(r);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 400) begin
      @(posedge clk);
      cyc++;
      #1;
      set_start(sel, (cyc + 1 == glitch_cyc) ? 1'b1 : 1'b0);
      sample(sel);
      if (cyc == 1) check({tag, "_busy"}, s_busy, 1);
      if (((cyc - 1) % 4 == 0) && ((cyc - 1) / 4 < (1 << n)))
        check({tag, "_estimulo"}, s_est, (cyc - 1) / 4);
      if (s_done == 1) seen = 1;
    end
    set_start(sel, 1'b0);
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
      r = exp_q.pop_front();
    end else begin
      r = exp_q.pop_front();
      check({tag, "_done_cycle"}, cyc, exp_cyc);
      check({tag, "_busy_end"}, s_busy, 0);
      check({tag, "_pass"}, s_pass, int'(r[31:24]));
      check({tag, "_err"}, s_err, int'(r[23:16]));
      check({tag, "_fvec"}, s_vec, int'(r[15:8]));
      check({tag, "_fmask"}, s_mask, int'(r[7:0]));
      check({tag, "_estimulo_hold"}, s_est, (1 << n) - 1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    reset_L   = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_a", 0);
    check_idle("reset_b", 1);
    @(negedge clk);
    reset_L = 1'b1;

    // Clean sweep on defaults, then a start pulse inside ESPERAR of vector 0.
    run("clean", 0, 2, 8, 0, -1, 17);
    run("glitch", 0, 2, 8, 0, 2, 17);
    // Faulty runs, each restarted from FIN.
    run("xor_est_stuck", 0, 2, 8, 1, -1, 17);
    run("all_inv", 0, 2, 8, 2, -1, 17);
    run("clean_after_fail", 0, 2, 8, 0, -1, 17);

    // Reset while vector 10 is settling (ESPERAR after edge 9).
    fault_a = 1;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    cyc = 0;
    while (cyc < 9) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("mid_reset_pre_state", int'(if_a.estado), int'(ESPERAR));
    check("mid_reset_pre_est", int'(if_a.estimulo), 2);
    reset_L = 1'b0;
    @(posedge clk);
    #1;
    check_idle("mid_reset", 0);
    @(negedge clk);
    reset_L = 1'b1;
    run("after_reset", 0, 2, 8, 0, -1, 17);

    // Wide instance with a narrow counter: saturation at 3.
    run("sat_b", 1, 3, 2, 2, -1, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
